bp_ctr_table: RTL and testbench

- Parametrised branch-predictor counter table with NUM_RD combinational lookup ports and one internal read-modify-write update port.
- The update port carries an index and a taken/not-taken outcome. The block applies the saturating-counter increment or decrement itself, so fetch and retire logic no longer compute the next counter value.
- Table initialisation is a synthesizable one-entry-per-cycle sweep instead of a single-cycle reset of every entry. The same sweep also serves as a flush on clear_i.
- Sits between fetch (lookups) and the branch-retire path (updates). Serves gshare, bimodal and chooser tables.

---
 rtl/bp_pkg.sv | 27 ++
 rtl/bp_ctr_sat.sv | 22 ++
 rtl/bp_ctr_table.sv | 122 ++++++++++++
 tb/tb_bp_ctr_table.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-predictor counter tables.
// sat_update is the fixed-width step at the default counter width.
package bp_pkg;

  typedef enum logic [0:0] {
    BP_INIT = 1'b0,
    BP_RUN  = 1'b1
  } bp_state_t;

  localparam int unsigned BP_CTR_W    = 2;
  localparam int unsigned CTR_MAX     = (1 << BP_CTR_W) - 1;
  localparam int unsigned BP_INIT_VAL = 2;

  function automatic logic [BP_CTR_W-1:0] sat_update(input logic [BP_CTR_W-1:0] old,
                                                     input logic                taken);
    logic [BP_CTR_W-1:0] one;
    logic [BP_CTR_W-1:0] top;
    one = BP_CTR_W'(1);
    top = BP_CTR_W'(CTR_MAX);
    if (taken) begin
      return (old == top) ? old : old + one;
    end else begin
      return (old == '0) ? old : old - one;
    end
  endfunction

endpackage

// File: rtl/bp_ctr_sat.sv
// Combinational saturating up/down step for a CTR_W-bit predictor counter.
module bp_ctr_sat #(
  parameter int unsigned CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] ctr_o
);

  localparam logic [CTR_W-1:0] CtrMax = '1;
  localparam logic [CTR_W-1:0] CtrOne = CTR_W'(1);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CtrMax) ctr_o = ctr_i + CtrOne;
    end else begin
      if (ctr_i != '0) ctr_o = ctr_i - CtrOne;
    end
  end

endmodule

// File: rtl/bp_ctr_table.sv
// Branch-predictor counter table: combinational lookups, one-deep pending update with
// bypass, and a one-entry-per-cycle init sweep that doubles as a flush.
module bp_ctr_table
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned INDEX    = 10,
  parameter int unsigned CTR_W    = 2,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned INIT_VAL = BP_INIT_VAL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_RD*INDEX-1:0] rd_addr_i,
  output logic [NUM_RD*CTR_W-1:0] rd_data_o,
  input  logic                    upd_valid_i,
  input  logic [INDEX-1:0]        upd_idx_i,
  input  logic                    upd_taken_i,
  input  logic                    clear_i,
  output logic                    ready_o
);

  localparam logic [INDEX-1:0] LastIdx = INDEX'(DEPTH - 1);
  localparam logic [CTR_W-1:0] InitCtr = CTR_W'(INIT_VAL);

  logic [CTR_W-1:0] ram [DEPTH];

  bp_state_t        state_q, state_d;
  logic [INDEX-1:0] ptr_q, ptr_d;
  logic             pend_valid_q, pend_valid_d;
  logic [INDEX-1:0] pend_idx_q;
  logic [CTR_W-1:0] pend_val_q;

  logic             run;
  logic [CTR_W-1:0] upd_old;
  logic [CTR_W-1:0] upd_new;

  logic             ram_we;
  logic [INDEX-1:0] ram_waddr;
  logic [CTR_W-1:0] ram_wdata;

  assign run     = (state_q == BP_RUN);
  assign ready_o = run;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      BP_INIT: begin
        ptr_d = ptr_q + INDEX'(1);
        if (ptr_q == LastIdx) state_d = BP_RUN;
      end
      BP_RUN: begin
        if (clear_i) begin
          state_d = BP_INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = BP_INIT;
        ptr_d   = '0;
      end
    endcase
  end

  // The update's own read must see a write still sitting in the pending register.
  assign upd_old = (pend_valid_q && (pend_idx_q == upd_idx_i)) ? pend_val_q : ram[upd_idx_i];

  bp_ctr_sat #(
    .CTR_W(CTR_W)
  ) u_ctr_sat (
    .ctr_i  (upd_old),
    .taken_i(upd_taken_i),
    .ctr_o  (upd_new)
  );

  assign pend_valid_d = run && upd_valid_i && !clear_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BP_INIT;
      ptr_q        <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= upd_idx_i;
      pend_val_q   <= upd_new;
    end
  end

  // Single write port shared by the sweep and the retiring pending update.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = pend_idx_q;
    ram_wdata = pend_val_q;
    if (!reset) begin
      if (!run) begin
        ram_we    = 1'b1;
        ram_waddr = ptr_q;
        ram_wdata = InitCtr;
      end else if (pend_valid_q && !clear_i) begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [INDEX-1:0] idx;
    logic             hit;
    assign idx = rd_addr_i[p*INDEX +: INDEX];
    assign hit = pend_valid_q && (pend_idx_q == idx);
    assign rd_data_o[p*CTR_W +: CTR_W] = !run ? InitCtr :
                                         hit  ? pend_val_q : ram[idx];
  end

endmodule

// File: tb/tb_bp_ctr_table.sv
// Self-checking bench for bp_ctr_table: directed vector table, sweep timing sequences,
// and randomized traffic against an array-based reference model.
module tb_bp_ctr_table;

  localparam int DEPTH    = 1024;
  localparam int INDEX    = 10;
  localparam int CTR_W    = 2;
  localparam int NUM_RD   = 2;
  localparam int INIT_VAL = 2;
  localparam int CMAX     = (1 << CTR_W) - 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_RD*INDEX-1:0] rd_addr_i;
  logic [NUM_RD*CTR_W-1:0] rd_data_o;
  logic                    upd_valid_i;
  logic [INDEX-1:0]        upd_idx_i;
  logic                    upd_taken_i;
  logic                    clear_i;
  logic                    ready_o;

  bp_ctr_table #(
    .DEPTH   (DEPTH),
    .INDEX   (INDEX),
    .CTR_W   (CTR_W),
    .NUM_RD  (NUM_RD),
    .INIT_VAL(INIT_VAL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .upd_valid_i(upd_valid_i),
    .upd_idx_i  (upd_idx_i),
    .upd_taken_i(upd_taken_i),
    .clear_i    (clear_i),
    .ready_o    (ready_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: table contents as plain ints, plus "in sweep" flag and cycle count.
  int mem [DEPTH];
  bit m_run;
  int m_cnt;

  typedef struct {
    bit v;
    int idx;
    bit t;
    bit clr;
    int r0;
    int r1;
    int e0;
    int e1;
    bit erdy;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input bit t);
    if (t) return (v + 1 > CMAX) ? CMAX : v + 1;
    return (v - 1 < 0) ? 0 : v - 1;
  endfunction

  function automatic int lane(input int p);
    return int'(rd_data_o[p*CTR_W +: CTR_W]);
  endfunction

  task automatic set_rd(input int a0, input int a1);
    rd_addr_i = {INDEX'(a1), INDEX'(a0)};
  endtask

  task automatic set_upd(input bit v, input int idx, input bit t);
    upd_valid_i = v;
    upd_idx_i   = INDEX'(idx);
    upd_taken_i = t;
  endtask

  // Compare against the model mid-cycle, then advance the model across the edge.
  task automatic step();
    @(negedge clk);
    check("ready", int'(ready_o), int'(m_run));
    for (int p = 0; p < NUM_RD; p++) begin
      int ad;
      ad = int'(rd_addr_i[p*INDEX +: INDEX]);
      check($sformatf("model_rd%0d[%0d]", p, ad), lane(p), m_run ? mem[ad] : INIT_VAL);
    end
    @(posedge clk);
    if (reset) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (!m_run) begin
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_run = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = INIT_VAL;
      end
    end else if (clear_i) begin
      m_run = 1'b0;
      m_cnt = 0;
    end else if (upd_valid_i) begin
      mem[int'(upd_idx_i)] = sat(mem[int'(upd_idx_i)], upd_taken_i);
    end
    #1;
  endtask

  // Counts cycles with ready_o low; random updates during the sweep must be dropped.
  task automatic sweep_len(input int a0, input int a1, output int n);
    n = 0;
    while (!ready_o && n < 2 * DEPTH) begin
      set_rd(a0, a1);
      set_upd($urandom_range(0, 1), a0, $urandom_range(0, 1));
      n++;
      step();
    end
    set_upd(0, 0, 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    vecs[0]  = '{1, 5, 1, 0, 5, 6, 2, 2, 1};
    vecs[1]  = '{1, 5, 1, 0, 5, 6, 3, 2, 1};
    vecs[2]  = '{1, 5, 1, 0, 5, 6, 3, 2, 1};
    vecs[3]  = '{0, 0, 0, 0, 5, 6, 3, 2, 1};
    vecs[4]  = '{1, 9, 0, 0, 9, 9, 2, 2, 1};
    vecs[5]  = '{1, 9, 0, 0, 9, 9, 1, 1, 1};
    vecs[6]  = '{1, 9, 0, 0, 9, 9, 0, 0, 1};
    vecs[7]  = '{1, 9, 0, 0, 9, 9, 0, 0, 1};
    vecs[8]  = '{0, 0, 0, 0, 9, 9, 0, 0, 1};
    vecs[9]  = '{1, 12, 1, 0, 12, 12, 2, 2, 1};
    vecs[10] = '{1, 12, 0, 0, 12, 12, 3, 3, 1};
    vecs[11] = '{1, 12, 1, 0, 12, 12, 2, 2, 1};
    vecs[12] = '{1, 12, 0, 0, 12, 12, 3, 3, 1};
    vecs[13] = '{0, 0, 0, 0, 12, 12, 2, 2, 1};
    vecs[14] = '{1, 5, 0, 1, 5, 9, 3, 0, 1};

    reset   = 1'b1;
    clear_i = 1'b0;
    set_rd(0, DEPTH - 1);
    set_upd(0, 0, 0);
    @(posedge clk);
    m_run = 1'b0;
    m_cnt = 0;
    #1;
    step();
    step();
    reset = 1'b0;

    // Initial sweep: ready low for exactly DEPTH cycles, reads at both ends give INIT_VAL.
    sweep_len(0, DEPTH - 1, n);
    check("init_sweep_len", n, DEPTH);
    step();

    for (int i = 0; i < 15; i++) begin
      set_upd(vecs[i].v, vecs[i].idx, vecs[i].t);
      clear_i = vecs[i].clr;
      set_rd(vecs[i].r0, vecs[i].r1);
      #2;
      check($sformatf("vec%0d_ready", i), int'(ready_o), int'(vecs[i].erdy));
      check($sformatf("vec%0d_rd0", i), lane(0), vecs[i].e0);
      check($sformatf("vec%0d_rd1", i), lane(1), vecs[i].e1);
      step();
    end
    clear_i = 1'b0;
    set_upd(0, 0, 0);

    // Flush: ready drops right after the clear, modified entries come back as INIT_VAL.
    check("clear_ready_drop", int'(ready_o), 0);
    sweep_len(5, 9, n);
    check("clear_sweep_len", n, DEPTH);
    set_rd(5, 9);
    #2;
    check("flush_idx5", lane(0), INIT_VAL);
    check("flush_idx9", lane(1), INIT_VAL);
    step();

    // Reset in the middle of a sweep restarts it from the beginning.
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      set_rd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    sweep_len(0, DEPTH - 1, n);
    check("reset_midsweep_len", n, DEPTH);

    // Randomized traffic on a small index range to force bypass collisions.
    for (int i = 0; i < 3000; i++) begin
      set_rd($urandom_range(0, 15), $urandom_range(0, 15));
      set_upd($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 1));
      clear_i = ($urandom_range(0, 599) == 0);
      step();
    end
    clear_i = 1'b0;
    set_upd(0, 0, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
